// File: rtl/regfile_param_if.sv
// Register-file port bundle: write port, link path, read ports and status.
// master drives addresses/data (decode/writeback side), slave is the register file.
interface regfile_param_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   link_en;
    logic [WIDTH-1:0]       pc_in;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [WIDTH-1:0]       jump_reg;
    logic [15:0]            wr_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, link_en, pc_in, rd_addr,
        input  rd_data, jump_reg, wr_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, link_en, pc_in, rd_addr,
        output rd_data, jump_reg, wr_cnt
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised MIPS register file: NREAD combinational reads, data write, link write.
// Optional same-cycle write-to-read forwarding under `define REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int LINK_REG = DEPTH - 1,
    parameter int PC_INC   = 4,
    parameter int ZERO_REG = 1
) (
    input logic            clk,
    input logic            rst_n,
    regfile_param_if.slave bus
);
    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
    localparam bit            ZR       = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] link_val;
    logic             wr_commit;
    logic             link_commit;
    logic [1:0]       n_commit;
    logic [16:0]      cnt_sum;

    // Link wins a collision on LINK_REG; writes to a hardwired-zero register never commit.
    always_comb begin
        link_val    = bus.pc_in + WIDTH'(PC_INC);
        link_commit = bus.link_en && !(ZR && LINK_IDX == '0);
        wr_commit   = bus.wr_en && !(ZR && bus.wr_addr == '0)
                      && !(bus.link_en && bus.wr_addr == LINK_IDX);
        n_commit    = {1'b0, wr_commit} + {1'b0, link_commit};
        cnt_sum     = {1'b0, cnt_q} + 17'(n_commit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (wr_commit) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            if (link_commit) begin
                regs[LINK_IDX] <= link_val;
            end
            cnt_q <= cnt_sum[16] ? '1 : cnt_sum[15:0];
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] v;

        always_comb begin
            a = bus.rd_addr[k*AW +: AW];
            v = regs[a];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is gated by rst_n so reads stay 0 while reset is held.
            if (rst_n && bus.link_en && a == LINK_IDX) begin
                v = link_val;
            end else if (rst_n && bus.wr_en && a == bus.wr_addr) begin
                v = bus.wr_data;
            end
`endif
            if (ZR && a == '0) begin
                v = '0;
            end
        end

        assign bus.rd_data[k*WIDTH +: WIDTH] = v;
    end

    assign bus.jump_reg = bus.rd_data[WIDTH-1:0];
    assign bus.wr_cnt   = cnt_q;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters: 32x32, 2 read ports).
// An array/integer model of the architectural state is compared every cycle.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    regfile_param_if #(.WIDTH(32), .AW(5), .NREAD(2)) bus ();

    regfile_param #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .LINK_REG(31), .PC_INC(4), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m [32];
    int          mcnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n) begin
            if (bus.link_en && a == 5'd31) return bus.pc_in + 32'd4;
            if (bus.wr_en && a == bus.wr_addr) return bus.wr_data;
        end
`endif
        return m[a];
    endfunction

    // Architectural effect of one rising edge, from the current inputs.
    task automatic model_edge;
        int n;
        n = 0;
        if (!rst_n) return;
        if (bus.link_en) begin
            m[31] = bus.pc_in + 32'd4;
            n++;
        end
        if (bus.wr_en && bus.wr_addr != 5'd0 && !(bus.link_en && bus.wr_addr == 5'd31)) begin
            m[bus.wr_addr] = bus.wr_data;
            n++;
        end
        mcnt = (mcnt + n > 65535) ? 65535 : mcnt + n;
    endtask

    task automatic model_clear;
        foreach (m[i]) m[i] = 32'h0;
        mcnt = 0;
    endtask

    task automatic drv(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic len, input logic [31:0] pc,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_en   = wen;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.link_en = len;
        bus.pc_in   = pc;
        bus.rd_addr = {ra1, ra0};
    endtask

    task automatic step;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd0", bus.rd_data[31:0], exp_rd(bus.rd_addr[4:0]));
            chk("rd1", bus.rd_data[63:32], exp_rd(bus.rd_addr[9:5]));
            chk("jump_reg", bus.jump_reg, exp_rd(bus.rd_addr[4:0]));
            chk("wr_cnt", {16'h0, bus.wr_cnt}, mcnt[31:0]);
        end
    end

    initial begin
        int need;
        model_clear();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        step(); step();
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Preload then asynchronous reset mid-cycle; the write during reset is lost
        drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 5'd5, 5'd5);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd6);
        #1 chk("preload_r5", bus.rd_data[31:0], 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        model_clear();
        #1 chk("reset_r5", bus.rd_data[31:0], 32'h0);
        chk("reset_cnt", {16'h0, bus.wr_cnt}, 32'h0);
        drv(1'b1, 5'd6, 32'h00000001, 1'b0, 32'h0, 5'd5, 5'd6);
        step();
        rst_n = 1'b1;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd6);
        #1 chk("lost_write_r6", bus.rd_data[63:32], 32'h0);

        // Basic write/read on both ports
        drv(1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0, 5'd1, 5'd2);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd7, 5'd7);
        #1 chk("basic_p0", bus.rd_data[31:0], 32'h12345678);
        chk("basic_p1", bus.rd_data[63:32], 32'h12345678);
        chk("basic_cnt", {16'h0, bus.wr_cnt}, 32'd1);

        // Register 0 ignores writes
        drv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 5'd0, 5'd7);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        #1 chk("zero_r0", bus.rd_data[31:0], 32'h0);
        chk("zero_cnt", {16'h0, bus.wr_cnt}, 32'd1);

        // Link collides with data write on r31: link wins, one commit
        drv(1'b1, 5'd31, 32'hAAAA5555, 1'b1, 32'h00400020, 5'd3, 5'd4);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd31, 5'd0);
        #1 chk("link_r31", bus.rd_data[31:0], 32'h00400024);
        chk("link_cnt", {16'h0, bus.wr_cnt}, 32'd2);
        drv(1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFE, 5'd31, 5'd0);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd31, 5'd0);
        #1 chk("link_wrap", bus.rd_data[31:0], 32'h00000002);
        chk("wrap_cnt", {16'h0, bus.wr_cnt}, 32'd3);

        // Dual commit on distinct registers
        drv(1'b1, 5'd3, 32'h00000033, 1'b1, 32'h00000100, 5'd3, 5'd31);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd31);
        #1 chk("dual_r3", bus.rd_data[31:0], 32'h00000033);
        chk("dual_r31", bus.rd_data[63:32], 32'h00000104);
        chk("dual_cnt", {16'h0, bus.wr_cnt}, 32'd5);

        // Same-cycle read of the register being written
        drv(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 32'h0, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        #1 chk("fwd_same", bus.rd_data[31:0], 32'hCAFEF00D);
`else
        #1 chk("fwd_same", bus.rd_data[31:0], 32'h0);
`endif
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd9, 5'd9);
        #1 chk("fwd_next", bus.rd_data[31:0], 32'hCAFEF00D);
        chk("fwd_cnt", {16'h0, bus.wr_cnt}, 32'd6);

        // Mixed directed pattern, checked by the model each cycle
        for (int i = 0; i < 24; i++) begin
            drv(i % 4 != 3, 5'((i * 7) % 32), 32'h01010101 * i, i % 3 == 0, 32'h10 * i,
                5'((i + 1) % 32), 5'((i * 7) % 32));
            step();
        end

        // Drive the counter to 16'hFFFE, then check saturation
        need = 65534 - mcnt;
        if (need % 2 == 1) begin
            drv(1'b1, 5'd2, 32'h2, 1'b0, 32'h0, 5'd1, 5'd31);
            step();
        end
        for (int i = 0; i < need / 2; i++) begin
            drv(1'b1, 5'd1, 32'(i), 1'b1, 32'(i), 5'd1, 5'd31);
            step();
        end
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd31);
        #1 chk("cnt_fffe", {16'h0, bus.wr_cnt}, 32'h0000FFFE);
        drv(1'b1, 5'd3, 32'h3, 1'b1, 32'h0, 5'd1, 5'd31);
        step();
        #1 chk("cnt_sat", {16'h0, bus.wr_cnt}, 32'h0000FFFF);
        step();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd31);
        #1 chk("cnt_hold", {16'h0, bus.wr_cnt}, 32'h0000FFFF);
        step();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
